uplink_frame_sequencer: RTL
===========================

// Module: uplink_frame_sequencer
// PURPOSE
//  Frame-level controller for the uplink encoder/interleaver. Tracks frame phase from an external frame sync,
//  emits one load strobe per frame, and applies txDataRate/fecMode/bypass changes only on frame boundaries.
//  After a real mode change it holds the frame invalid for a flush period so no frame mixes old/new layouts.
// PARAMETERS
//  CLK_PER_FRAME  8  clk cycles per uplink frame (>=2)
//  FLUSH_FRAMES   2  invalid frames inserted after a config change or resync (>=1)
// PORTS
//  clk            in   1  datapath clock
//  rstn           in   1  asynchronous, active-low reset
//  frame_sync_i   in   1  1-cycle pulse marking phase 0 of a frame
//  cfg_update_i   in   1  1-cycle request to apply the cfg_* inputs
//  cfg_txDataRate_i in 1  requested rate: 0=5G12, 1=10G24
//  cfg_fecMode_i  in   1  requested FEC: 0=FEC5, 1=FEC12
//  cfg_bypass_i   in   1  requested interleaver bypass
//  txDataRate_o   out  1  applied rate, drives the interleaver
//  fecMode_o      out  1  applied FEC mode
//  bypass_o       out  1  applied bypass
//  frame_strobe_o out  1  1-cycle pulse at phase 0 of each frame while locked
//  data_valid_o   out  1  current frame carries user data (low = idle/flush frame)
//  cfg_busy_o     out  1  a captured update is not yet acknowledged
//  cfg_ack_o      out  1  1-cycle pulse when an update completes
//  sync_err_o     out  1  1-cycle pulse when frame_sync_i arrives off-phase
//  state_o        out  2  FSM state: 0=WAIT_SYNC 1=RUN 2=FLUSH
// BEHAVIOUR
//  Reset: state WAIT_SYNC; phase=0; all outputs 0. Reset is async assert, sync deassert at clk.
//  Phase counter: 0..CLK_PER_FRAME-1, wraps to 0. Forced to 0 on frame_sync_i.
//   - A sync when phase != CLK_PER_FRAME-1 is off-phase.
//   - In RUN or FLUSH an off-phase sync pulses sync_err_o next cycle and enters FLUSH with a full FLUSH_FRAMES count.
//  frame_strobe_o: registered; high exactly 1 cycle after each phase-0 cycle in RUN/FLUSH. Never high in WAIT_SYNC.
//  WAIT_SYNC: outputs idle. The first frame_sync_i -> FLUSH (FLUSH_FRAMES count), so data_valid_o stays 0 after lock.
//  RUN: data_valid_o=1.
//  FLUSH: data_valid_o=0.
//   - Decrements on each phase-0 cycle.
//   - When the count reaches 0 at a phase-0 cycle -> RUN; data_valid_o=1 from that frame.
//  Config capture:
//   - cfg_update_i in any state latches the cfg_* inputs into shadow regs and sets cfg_busy_o next cycle.
//   - A new update while busy overwrites the shadow; the last request wins and produces a single ack.
//  Config apply, only in RUN, at the first phase-0 cycle with busy=1:
//   - Shadow differs from applied: the *_o config regs update that cycle, visible with frame_strobe_o.
//     Enter FLUSH (FLUSH_FRAMES). cfg_ack_o pulses and busy clears on return to RUN.
//   - Shadow equals applied: no flush; cfg_ack_o pulses and busy clears that same boundary.
//   - A pending update in WAIT_SYNC/FLUSH waits until RUN.
//  Simultaneous events:
//   - cfg_update_i with an apply boundary: the apply uses the old shadow; the new request stays pending (busy stays 1).
//   - Off-phase sync with an apply boundary: resync wins; apply deferred.
//  Applied config never changes except at a phase-0 cycle, or at reset to 0/0/0.
//  Latency: update request -> applied <= CLK_PER_FRAME+1 cycles in RUN; ack after a further FLUSH_FRAMES frames.
// TESTING
//  T1 reset, then sync pulses every 8 clk:
//     strobe every 8 cycles; data_valid_o 0 for 2 frames then 1; state 0->2->1.
//  T2 RUN, update 5G12/FEC5 -> 10G24/FEC12:
//     *_o change at next boundary; data_valid_o 0 for 2 frames; ack 1 cycle when back in RUN.
//  T3 update with an identical config:
//     ack at next boundary; data_valid_o stays 1; no FLUSH entry.
//  T4 two updates 3 cycles apart before a boundary:
//     only the second config is applied; exactly one ack.
//  T5 sync pulse at phase 3 in RUN:
//     sync_err_o 1 cycle; phase realigned; 2 invalid frames; strobe follows the new alignment.
//  T6 rstn low during FLUSH with busy=1:
//     all outputs 0 immediately; pending update dropped; after release returns to WAIT_SYNC.

Source files
------------

// File: rtl/uplink_frame_sequencer.sv
// Frame-level controller for the uplink encoder/interleaver: tracks frame phase from frame sync,
// strobes each frame, and applies rate/FEC/bypass changes only on frame boundaries with a flush period.
module uplink_frame_sequencer #(
  parameter int CLK_PER_FRAME = 8,
  parameter int FLUSH_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       frame_sync_i,
  input  logic       cfg_update_i,
  input  logic       cfg_txDataRate_i,
  input  logic       cfg_fecMode_i,
  input  logic       cfg_bypass_i,
  output logic       txDataRate_o,
  output logic       fecMode_o,
  output logic       bypass_o,
  output logic       frame_strobe_o,
  output logic       data_valid_o,
  output logic       cfg_busy_o,
  output logic       cfg_ack_o,
  output logic       sync_err_o,
  output logic [1:0] state_o
);

  localparam int PW = $clog2(CLK_PER_FRAME);
  localparam int CW = $clog2(FLUSH_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_RUN       = 2'd1,
    ST_FLUSH     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [2:0]      shadow_q, shadow_d;
  logic [2:0]      cfg_q, cfg_d;
  logic            pending_q, pending_d;
  logic            await_ack_q, await_ack_d;
  logic            strobe_q, strobe_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  logic phase_last;
  logic boundary;
  logic off_phase;

  assign phase_last = (phase_q == PW'(CLK_PER_FRAME - 1));
  assign boundary   = (phase_q == '0);
  assign off_phase  = frame_sync_i && !phase_last;

  // Flush count holds the invalid frames still to come after the current one; a
  // sync-triggered entry lands one cycle before its first flush frame, hence the full load.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_last ? '0 : phase_q + PW'(1);
    flush_cnt_d = flush_cnt_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    pending_d   = pending_q;
    await_ack_d = await_ack_q;
    strobe_d    = boundary && (state_q != ST_WAIT_SYNC);
    ack_d       = 1'b0;
    err_d       = 1'b0;

    if (frame_sync_i) phase_d = '0;

    case (state_q)
      ST_WAIT_SYNC: begin
        if (frame_sync_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = CW'(FLUSH_FRAMES);
        end
      end
      ST_RUN: begin
        if (off_phase) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = CW'(FLUSH_FRAMES);
          err_d       = 1'b1;
        end else if (boundary && pending_q) begin
          pending_d = 1'b0;
          if (shadow_q != cfg_q) begin
            cfg_d       = shadow_q;
            state_d     = ST_FLUSH;
            flush_cnt_d = CW'(FLUSH_FRAMES - 1);
            await_ack_d = 1'b1;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (off_phase) begin
          flush_cnt_d = CW'(FLUSH_FRAMES);
          err_d       = 1'b1;
        end else if (boundary) begin
          if (flush_cnt_q == '0) begin
            state_d = ST_RUN;
            if (await_ack_q) begin
              ack_d       = 1'b1;
              await_ack_d = 1'b0;
            end
          end else begin
            flush_cnt_d = flush_cnt_q - CW'(1);
          end
        end
      end
      default: state_d = ST_WAIT_SYNC;
    endcase

    // A request arriving on an apply boundary stays pending for the next one.
    if (cfg_update_i) begin
      shadow_d  = {cfg_txDataRate_i, cfg_fecMode_i, cfg_bypass_i};
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_WAIT_SYNC;
      phase_q     <= '0;
      flush_cnt_q <= '0;
      shadow_q    <= '0;
      cfg_q       <= '0;
      pending_q   <= 1'b0;
      await_ack_q <= 1'b0;
      strobe_q    <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      flush_cnt_q <= flush_cnt_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      pending_q   <= pending_d;
      await_ack_q <= await_ack_d;
      strobe_q    <= strobe_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign txDataRate_o   = cfg_q[2];
  assign fecMode_o      = cfg_q[1];
  assign bypass_o       = cfg_q[0];
  assign frame_strobe_o = strobe_q;
  assign data_valid_o   = (state_q == ST_RUN);
  assign cfg_busy_o     = pending_q | await_ack_q;
  assign cfg_ack_o      = ack_q;
  assign sync_err_o     = err_q;
  assign state_o        = state_q;

endmodule
